fpusqr_wb_align: RTL

FPUSQR_WB_ALIGN -- requirements
Module: fpusqr_wb_align

---
 rtl/fpusqr_wb_align.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fpusqr_wb_align.sv
// fpusqr_wb_align: aligns sqrt/div result tags with their late data word and
// queues the merged results for a shared writeback port.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   except              pipeline flush
//   outEn/outII/outOp   result enable (4'b1001 = tag), instruction index, opcode
//   FUreg/FUwen         destination register, result write enable
//   outAltData          result data, arrives DLY cycles after its tag
//   wb_gnt              writeback grant for the current cycle
//   wb_req/wb_reg/wb_II/wb_op/wb_data  FIFO head (zero when empty)
//   ret_en/ret_II       registered retire pulse for the popped entry
//   sq_pause            back-pressure: queued + in-flight results >= DEPTH
//   ovf                 sticky overflow (push into a full FIFO)
module fpusqr_wb_align #(
    parameter logic H     = 1'b0,
    parameter int   DEPTH = 4,
    parameter int   DLY   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      except,
    input  logic [3:0]                outEn,
    input  logic [9:0]                outII,
    input  logic [12:0]               outOp,
    input  logic [8:0]                FUreg,
    input  logic                      FUwen,
    input  logic [(H ? 84 : 68)-1:0]  outAltData,
    input  logic                      wb_gnt,
    output logic                      wb_req,
    output logic [8:0]                wb_reg,
    output logic [9:0]                wb_II,
    output logic [12:0]               wb_op,
    output logic [(H ? 84 : 68)-1:0]  wb_data,
    output logic                      ret_en,
    output logic [9:0]                ret_II,
    output logic                      sq_pause,
    output logic                      ovf
);
    localparam int W  = H ? 84 : 68;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DLY + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // tag layout: {II[31:22], op[21:9], reg[8:0]}
    logic [DLY-1:0] tagVld;
    logic [31:0]    tagLine [DLY];

    logic [31:0]    memTag  [DEPTH];
    logic [W-1:0]   memData [DEPTH];
    logic [PW-1:0]  rdPtr, wrPtr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  inflight;
    logic [31:0]    occ;

    logic capture, push, pop, full, doWrite;
    logic [31:0] headTag;

    assign capture = FUwen && (outEn == 4'b1001) && !except;
    assign push    = tagVld[DLY-1] && !except;
    assign full    = (count == CW'(DEPTH));
    assign wb_req  = (count != '0);
    assign pop     = wb_req && wb_gnt;
    // a full FIFO can only accept a push when the head leaves in the same cycle
    assign doWrite = push && (!full || pop);

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // fixed-latency tag line, never stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tagVld <= '0;
            for (int i = 0; i < DLY; i++) tagLine[i] <= '0;
        end else if (except) begin
            tagVld <= '0;
        end else begin
            for (int i = 0; i < DLY; i++) begin
                if (i == 0) begin
                    tagVld[i]  <= capture;
                    tagLine[i] <= {outII, outOp, FUreg};
                end else begin
                    tagVld[i]  <= tagVld[i-1];
                    tagLine[i] <= tagLine[i-1];
                end
            end
        end
    end

    // storage needs no reset: count gates everything that is read
    always_ff @(posedge clk) begin
        if (doWrite) begin
            memTag[wrPtr]  <= tagLine[DLY-1];
            memData[wrPtr] <= outAltData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            ret_en <= 1'b0;
            ret_II <= '0;
        end else if (except) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            count  <= '0;
            ret_en <= 1'b0;
        end else begin
            ret_en <= pop;
            if (pop) ret_II <= headTag[31:22];
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else begin
                if (push) wrPtr <= nextPtr(wrPtr);
                if (pop)  rdPtr <= nextPtr(rdPtr);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DLY; i++) inflight = inflight + IW'(tagVld[i]);
    end

    assign occ      = 32'(count) + 32'(inflight);
    assign sq_pause = (occ >= 32'(DEPTH));

    assign headTag = wb_req ? memTag[rdPtr]  : '0;
    assign wb_data = wb_req ? memData[rdPtr] : '0;
    assign wb_II   = headTag[31:22];
    assign wb_op   = headTag[21:9];
    assign wb_reg  = headTag[8:0];

endmodule
